// File: rtl/w0rm_core_register_file_mp.sv
// Multi-ported register file with optional write-to-read bypass, registered reads,
// and a hardwired zero register. Highest-index write port wins on address collisions.
module w0rm_core_register_file_mp #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned NUM_REGISTERS   = 4,
    parameter int unsigned NUM_READ_PORTS  = 2,
    parameter int unsigned NUM_WRITE_PORTS = 1,
    parameter int unsigned SINGLE_CYCLE    = 1,
    parameter int unsigned BYPASS          = 1,
    parameter int unsigned ZERO_REG        = 0,
    localparam int unsigned ADDR_WIDTH     = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0]  port_read_addr,
    input  logic [NUM_READ_PORTS-1:0]             port_read_enable,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  port_read_data,
    output logic [NUM_READ_PORTS-1:0]             port_read_valid,
    input  logic [NUM_WRITE_PORTS*ADDR_WIDTH-1:0] port_write_addr,
    input  logic [NUM_WRITE_PORTS-1:0]            port_write_enable,
    input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] port_write_data
);

    logic [DATA_WIDTH-1:0]      regs_q  [NUM_REGISTERS];
    logic [DATA_WIDTH-1:0]      regs_d  [NUM_REGISTERS];
    logic [ADDR_WIDTH-1:0]      wr_addr [NUM_WRITE_PORTS];
    logic [DATA_WIDTH-1:0]      wr_data [NUM_WRITE_PORTS];
    logic [ADDR_WIDTH-1:0]      rd_addr [NUM_READ_PORTS];
    logic [DATA_WIDTH-1:0]      rd_val  [NUM_READ_PORTS];
    logic [NUM_WRITE_PORTS-1:0] wr_en;

    // Gating with reset_n keeps bypassed write data off the read outputs during reset.
    assign wr_en = port_write_enable & {NUM_WRITE_PORTS{reset_n}};

    for (genvar j = 0; j < NUM_WRITE_PORTS; j++) begin : g_wr_unpack
        assign wr_addr[j] = port_write_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
        assign wr_data[j] = port_write_data[j*DATA_WIDTH +: DATA_WIDTH];
    end

    for (genvar i = 0; i < NUM_READ_PORTS; i++) begin : g_rd_unpack
        assign rd_addr[i] = port_read_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end

    function automatic logic writable(input logic [ADDR_WIDTH-1:0] a);
        return (32'(a) < NUM_REGISTERS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Ascending port order makes the highest-index writer win.
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NUM_WRITE_PORTS; j++) begin
            if (wr_en[j] && writable(wr_addr[j])) begin
                regs_d[wr_addr[j]] = wr_data[j];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_REGISTERS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Bypass reads the post-write view, which already folds in priority and zero-reg rules.
    always_comb begin
        for (int i = 0; i < NUM_READ_PORTS; i++) begin
            rd_val[i] = '0;
            if (32'(rd_addr[i]) < NUM_REGISTERS) begin
                rd_val[i] = (BYPASS != 0) ? regs_d[rd_addr[i]] : regs_q[rd_addr[i]];
            end
        end
    end

    if (SINGLE_CYCLE != 0) begin : g_comb_read
        logic unused_read_enable;
        assign unused_read_enable = ^port_read_enable;
        assign port_read_valid    = {NUM_READ_PORTS{reset_n}};
        for (genvar i = 0; i < NUM_READ_PORTS; i++) begin : g_out
            assign port_read_data[i*DATA_WIDTH +: DATA_WIDTH] = rd_val[i];
        end
    end else begin : g_reg_read
        logic [DATA_WIDTH-1:0]     data_q [NUM_READ_PORTS];
        logic [NUM_READ_PORTS-1:0] valid_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                valid_q <= '0;
                for (int i = 0; i < NUM_READ_PORTS; i++) begin
                    data_q[i] <= '0;
                end
            end else begin
                valid_q <= port_read_enable;
                for (int i = 0; i < NUM_READ_PORTS; i++) begin
                    if (port_read_enable[i]) begin
                        data_q[i] <= rd_val[i];
                    end
                end
            end
        end

        assign port_read_valid = valid_q;
        for (genvar i = 0; i < NUM_READ_PORTS; i++) begin : g_out
            assign port_read_data[i*DATA_WIDTH +: DATA_WIDTH] = data_q[i];
        end
    end

endmodule
